// File: rtl/mul_seq_param_if.sv
// -----------------------------------------------------------------------------
// mul_seq_param_if : operand/handshake/result bundle for mul_seq_param
// rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

interface mul_seq_param_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH)
);
   logic                 start;
   logic                 sgn;
   logic [WIDTH-1:0]     mulcand;
   logic [WIDTH-1:0]     mulplier;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   product;
   logic [CNT_W-1:0]     counter;

   modport master (
      output start, sgn, mulcand, mulplier,
      input  busy, done, product, counter
   );

   modport slave (
      input  start, sgn, mulcand, mulplier,
      output busy, done, product, counter
   );
endinterface

`default_nettype wire

// File: rtl/mul_seq_param.sv
// -----------------------------------------------------------------------------
// mul_seq_param : sequential shift-add multiplier, one multiplier bit per clock
// rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module mul_seq_param #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  wire logic        clk,
   input  wire logic        rst,
   mul_seq_param_if.slave   bus
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]           r_state;
   logic [1:0]           w_state_nxt;
   logic                 r_busy;
   logic                 r_done;
   logic                 w_busy_nxt;
   logic                 w_done_nxt;

   logic [WIDTH:0]       r_acc;
   logic [WIDTH-1:0]     r_mpl;
   logic [WIDTH-1:0]     r_mcand;
   logic                 r_sgn;
   logic [CNT_W-1:0]     r_cnt;
   logic [2*WIDTH-1:0]   r_product;

   logic                 w_accept;
   logic                 w_last;
   logic [WIDTH:0]       w_ext;
   logic [WIDTH:0]       w_sum;
   logic [WIDTH:0]       w_acc_sh;
   logic [WIDTH-1:0]     w_mpl_sh;

   assign w_accept = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));
   assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

   // The final step of a signed multiply subtracts: the multiplier MSB weighs -2^(WIDTH-1).
   assign w_ext    = r_sgn ? {r_mcand[WIDTH-1], r_mcand} : {1'b0, r_mcand};
   assign w_sum    = !r_mpl[0]          ? r_acc :
                     (w_last && r_sgn)  ? (r_acc - w_ext) :
                                          (r_acc + w_ext);
   assign w_acc_sh = {r_sgn & w_sum[WIDTH], w_sum[WIDTH:1]};
   assign w_mpl_sh = {w_sum[0], r_mpl[WIDTH-1:1]};

   // State register, with the registered busy/done flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  w_state_nxt = bus.start ? S_RUN : S_IDLE;
         S_RUN:   w_state_nxt = w_last ? S_DONE : S_RUN;
         S_DONE:  w_state_nxt = bus.start ? S_RUN : S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_busy_nxt = (w_state_nxt == S_RUN);
      w_done_nxt = (w_state_nxt == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc     <= '0;
         r_mpl     <= '0;
         r_mcand   <= '0;
         r_sgn     <= 1'b0;
         r_cnt     <= '0;
         r_product <= '0;
      end else if (w_accept) begin
         r_acc     <= '0;
         r_mpl     <= bus.mulplier;
         r_mcand   <= bus.mulcand;
         r_sgn     <= bus.sgn;
         r_cnt     <= '0;
      end else if (r_state == S_RUN) begin
         r_acc <= w_acc_sh;
         r_mpl <= w_mpl_sh;
         if (w_last) begin
            r_cnt     <= '0;
            r_product <= {w_acc_sh[WIDTH-1:0], w_mpl_sh};
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign bus.busy    = r_busy;
   assign bus.done    = r_done;
   assign bus.product = r_product;
   assign bus.counter = r_cnt;

endmodule

`default_nettype wire
